// File: rtl/blackjack_pkg.sv
// Shared blackjack constants and the deck loader state encoding.
package blackjack_pkg;

    localparam int DECK_SIZE  = 52;
    localparam int CARD_W     = 6;
    localparam int RANKS      = 13;
    localparam int SUITS      = 4;
    localparam int CODES      = RANKS * SUITS;
    localparam int ACE_VALUE  = 11;
    localparam int FACE_VALUE = 10;
    localparam int RANK_W     = 4;
    localparam int SUIT_W     = 2;
    localparam int VALUE_W    = 4;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_EMPTY = 2'd2
    } deck_state_t;

endpackage

// File: rtl/deck_loader_if.sv
// Card-load stream from the shuffler and deal handshake to the game controller.
interface deck_loader_if;
    import blackjack_pkg::*;

    logic                load_flag;
    logic [CARD_W-1:0]   card_in;
    logic                shuffle_req;
    logic                deck_ready;
    logic                deck_empty;
    logic [CARD_W-1:0]   cards_left;
    logic                deal_req;
    logic                deal_valid;
    logic [CARD_W-1:0]   deal_card;
    logic [RANK_W-1:0]   deal_rank;
    logic [SUIT_W-1:0]   deal_suit;
    logic [VALUE_W-1:0]  deal_value;
    logic                deal_err;
    logic                load_err;

    modport master (
        output load_flag, card_in, deal_req,
        input  shuffle_req, deck_ready, deck_empty, cards_left, deal_valid,
               deal_card, deal_rank, deal_suit, deal_value, deal_err, load_err
    );

    modport slave (
        input  load_flag, card_in, deal_req,
        output shuffle_req, deck_ready, deck_empty, cards_left, deal_valid,
               deal_card, deal_rank, deal_suit, deal_value, deal_err, load_err
    );

endinterface

// File: rtl/card_decode.sv
// Combinational card code -> rank/suit/point value; codes outside the deck decode to zeros.
module card_decode
    import blackjack_pkg::*;
(
    input  logic [CARD_W-1:0]  code,
    output logic [RANK_W-1:0]  rank,
    output logic [SUIT_W-1:0]  suit,
    output logic [VALUE_W-1:0] value
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves one unassigned and infers a latch.
        rank  = '0;
        suit  = '0;
        value = '0;
        if (code < CARD_W'(CODES)) begin
            suit = SUIT_W'(code / CARD_W'(RANKS));
            rank = RANK_W'(code % CARD_W'(RANKS)) + RANK_W'(1);
            if (rank == RANK_W'(1))
                value = VALUE_W'(ACE_VALUE);
            else if (rank >= RANK_W'(FACE_VALUE))
                value = VALUE_W'(FACE_VALUE);
            else
                value = rank;
        end
    end

endmodule

// File: rtl/deck_loader.sv
// Captures a serialized deck from the shuffler, flags bad/duplicate codes, and deals cards FIFO.
module deck_loader #(
    parameter int LOAD_PERIOD = 4,
    parameter int DECK_SIZE   = 52
) (
    input  logic          clk,
    input  logic          rst,
    deck_loader_if.slave  bus
);
    import blackjack_pkg::*;

    localparam int PH_W = (LOAD_PERIOD > 1) ? $clog2(LOAD_PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(LOAD_PERIOD - 1);

    deck_state_t          state;
    logic [PH_W-1:0]      phase;
    logic [CARD_W-1:0]    wr_ptr;
    logic [CARD_W-1:0]    rd_ptr;
    logic [CODES-1:0]     seen;
    logic [CARD_W-1:0]    store [DECK_SIZE];

    logic                 capture;
    logic                 code_bad;
    logic [CARD_W-1:0]    rd_code;
    logic [RANK_W-1:0]    dec_rank;
    logic [SUIT_W-1:0]    dec_suit;
    logic [VALUE_W-1:0]   dec_value;

    assign capture  = (state == ST_LOAD) && bus.load_flag && (phase == PH_LAST);
    assign code_bad = (bus.card_in >= CARD_W'(CODES)) || seen[bus.card_in];
    assign rd_code  = store[rd_ptr];

    card_decode u_decode (
        .code  (rd_code),
        .rank  (dec_rank),
        .suit  (dec_suit),
        .value (dec_value)
    );

    // NOTE: the deck store is plain memory with no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (capture)
            store[wr_ptr] <= bus.card_in;
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_LOAD;
            phase           <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            seen            <= '0;
            bus.load_err    <= 1'b0;
            bus.shuffle_req <= 1'b1;
            bus.deck_ready  <= 1'b0;
            bus.deck_empty  <= 1'b0;
            bus.cards_left  <= '0;
            bus.deal_valid  <= 1'b0;
            bus.deal_err    <= 1'b0;
            bus.deal_card   <= '0;
            bus.deal_rank   <= '0;
            bus.deal_suit   <= '0;
            bus.deal_value  <= '0;
        end else begin
            bus.deal_valid <= 1'b0;
            bus.deal_err   <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (bus.deal_req)
                        bus.deal_err <= 1'b1;
                    if (capture) begin
                        phase  <= '0;
                        wr_ptr <= wr_ptr + CARD_W'(1);
                        // Bad codes are still stored and counted so the deck length stays fixed.
                        if (code_bad)
                            bus.load_err <= 1'b1;
                        else
                            seen[bus.card_in] <= 1'b1;
                        if (wr_ptr == CARD_W'(DECK_SIZE - 1)) begin
                            state           <= ST_READY;
                            rd_ptr          <= '0;
                            bus.cards_left  <= CARD_W'(DECK_SIZE);
                            bus.shuffle_req <= 1'b0;
                            bus.deck_ready  <= 1'b1;
                        end
                    end else if (bus.load_flag) begin
                        phase <= phase + PH_W'(1);
                    end
                end
                ST_READY: begin
                    if (bus.deal_req) begin
                        bus.deal_valid <= 1'b1;
                        bus.deal_card  <= rd_code;
                        bus.deal_rank  <= dec_rank;
                        bus.deal_suit  <= dec_suit;
                        bus.deal_value <= dec_value;
                        rd_ptr         <= rd_ptr + CARD_W'(1);
                        bus.cards_left <= bus.cards_left - CARD_W'(1);
                        if (bus.cards_left == CARD_W'(1)) begin
                            state          <= ST_EMPTY;
                            bus.deck_ready <= 1'b0;
                            bus.deck_empty <= 1'b1;
                        end
                    end
                end
                ST_EMPTY: begin
                    if (bus.deal_req)
                        bus.deal_err <= 1'b1;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: doc/deck_loader.md
# deck_loader

Receive side of the shuffler's card-load stream. Captures the 52 serialized card codes into an internal deck store, checks the deck for duplicate and out-of-range codes, then deals cards one at a time to the game controller through a request/valid handshake. Each dealt card is decoded into rank, suit and blackjack point value.

## Interface
Parameters:
- `LOAD_PERIOD`, default 4: number of `load_flag`-high clock edges between successive card words on `card_in`.
- `DECK_SIZE`, default 52: number of cards captured per deck.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `load_flag`  in  1  from shuffler; high while the card stream is being presented.
- `card_in`  in  6  card code from shuffler, 0..51.
- `shuffle_req`  out  1  drives the shuffler's shuffle enable; high until the deck is fully captured.
- `deck_ready`  out  1  high in READY state.
- `deck_empty`  out  1  high in EMPTY state.
- `cards_left`  out  6  number of undealt cards.
- `deal_req`  in  1  single-cycle request for the next card.
- `deal_valid`  out  1  one-cycle pulse; deal outputs are valid.
- `deal_card`  out  6  raw card code dealt.
- `deal_rank`  out  4  rank, 1 (ace) .. 13 (king).
- `deal_suit`  out  2  suit, 0..3.
- `deal_value`  out  4  point value: ace 11, 2..10 face value, J/Q/K 10.
- `deal_err`  out  1  one-cycle pulse; `deal_req` was refused.
- `load_err`  out  1  sticky; a duplicate or out-of-range code was captured.

## Operation
State machine with three states: LOAD, READY, EMPTY. Reset enters LOAD.

LOAD:
- A phase counter (0..`LOAD_PERIOD`-1) increments on every edge where `load_flag` is sampled high.
- A capture occurs on the edge where the counter would reach `LOAD_PERIOD`; the counter then wraps to 0.
- On each capture, `card_in` is written to store[`wr_ptr`] and `wr_ptr` increments.
- The 52-bit seen-mask is checked on each capture:
  - Code ≥ 52 or already seen: `load_err` is set. The card is still stored and counted.
  - Otherwise the code's mask bit is set.
- After capture number `DECK_SIZE`: go to READY, set `cards_left` = 52 and `rd_ptr` = 0, and drop `shuffle_req`.
- `load_flag` remaining high afterwards is ignored.
- `deal_req` in LOAD produces a `deal_err` pulse.

READY:
- On `deal_req`, store[`rd_ptr`] is decoded, then `rd_ptr` increments and `cards_left` decrements.
- Deal order equals capture order (FIFO).
- When `cards_left` goes 1→0, go to EMPTY.

EMPTY:
- `deal_req` produces a `deal_err` pulse; no other effect.
- Only `rst` leaves EMPTY.

Decode of code c (0..51):
- suit = c / 13
- rank = (c mod 13) + 1
- value = 11 if rank = 1; 10 if rank ≥ 10; otherwise rank.
- Codes ≥ 52 decode to rank 0, suit 0, value 0.

Reset mid-operation aborts any load or deal and clears the store pointers, phase counter, mask and `load_err`. Store contents need no reset.

## Timing
- Reset values:
  - `shuffle_req` = 1
  - all other outputs 0, including `cards_left` = 0 in LOAD
  - phase counter, `wr_ptr`, `rd_ptr` = 0
- First capture occurs on the `LOAD_PERIOD`-th edge at which `load_flag` is sampled high. Later captures follow every `LOAD_PERIOD` such edges.
- `deck_ready` and the `shuffle_req` drop are registered: both change on the same edge as the 52nd capture.
- Deal latency is 1: `deal_req` sampled at edge N gives `deal_valid`, card, rank, suit and value registered at edge N, visible until edge N+1.
- `cards_left` updates on the same edge.
- Back-to-back `deal_req` on consecutive cycles is legal and gives one card per cycle.
- `deal_card`, `deal_rank`, `deal_suit` and `deal_value` hold the last dealt card between deals.

## Structure
- Shared package `blackjack_pkg` holds:
  - `DECK_SIZE`, `CARD_W` = 6, `RANKS` = 13, `SUITS` = 4
  - `ACE_VALUE` = 11, `FACE_VALUE` = 10
  - the state encoding for LOAD / READY / EMPTY
- Sub-module `card_decode` is a combinational code→rank/suit/value decoder. It is reused by the hand-scoring logic.

## Test plan
- Stream codes 0..51 with `load_flag` held high and words changing every 4 edges → exactly 52 captures; `deck_ready` = 1; `cards_left` = 52; `load_err` = 0; `shuffle_req` = 0.
- Deal the first four cards of deck 0,12,14,22 → (rank 1, suit 0, value 11), (13, 0, 10), (2, 1, 2), (10, 1, 10); each `deal_valid` arrives one cycle after its `deal_req`.
- 52 consecutive deals, then one more `deal_req` → `deck_empty` = 1; `cards_left` = 0; the 53rd request gives `deal_err` = 1 and `deal_valid` = 0.
- Stream containing 7 twice, or code 60 → `load_err` rises on that capture and stays set; still exactly 52 captures; code 60 deals as rank 0.
- `deal_req` during LOAD → `deal_err` pulse; `cards_left` and `wr_ptr` unaffected.
- `rst` after 20 captures, then a full 52-card stream → `shuffle_req` returns to 1, the load restarts from `wr_ptr` 0, and the first dealt card is the first card of the new stream.
